// File: rtl/checker_wb_feeder.sv
// Wishbone write master that unpacks a 64-bit stream into pairs of 32-bit writes into checker memory.
// Optional build macro: CHECKER_FEEDER_TIMEOUT_EN adds a 16-bit ack timeout on the strobe.
module checker_wb_feeder #(
  parameter logic [3:0] csr_addr  = 4'h0,
  parameter int         adr_width = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WR_LO, S_WR_HI, S_DONE} state_t;
  state_t r_state, w_next;

  logic [28:0]          r_base;
  logic [31:0]          r_ptr_base;
  logic [adr_width-1:0] r_off;
  logic [31:0]          r_count;
  logic                 r_busy, r_irq_en, r_done, r_timeout, r_last;
  logic [63:0]          r_data;
  logic                 r_stb, r_cyc;
  logic [31:0]          r_adr, r_dat, r_csr_do;

  logic                 w_csr_sel, w_wr_ctrl, w_wr_base, w_wr_stat;
  logic                 w_start, w_hs, w_ack, w_to;
  logic [adr_width-1:0] w_win_lo, w_win_hi;
  logic [31:0]          w_adr_lo, w_adr_hi, w_csr_rd;
  logic                 w_unused;

  assign w_csr_sel = (csr_a[13:10] == csr_addr);
  assign w_wr_ctrl = csr_we & w_csr_sel & (csr_a[2:0] == 3'd0);
  assign w_wr_base = csr_we & w_csr_sel & (csr_a[2:0] == 3'd1);
  assign w_wr_stat = csr_we & w_csr_sel & (csr_a[2:0] == 3'd3);
  assign w_start   = w_wr_ctrl & csr_di[0] & (r_state == S_IDLE);
  assign w_hs      = s_valid & s_ready;
  assign w_ack     = r_stb & wb_ack_i;
  assign w_unused  = ^{csr_a[9:3], csr_di[2]};

  // Offset wraps inside the low adr_width bits; the bits above come straight from BASE.
  assign w_win_lo = r_ptr_base[adr_width-1:0] + r_off;
  assign w_win_hi = w_win_lo + adr_width'(4);
  assign w_adr_lo = {r_ptr_base[31:adr_width], w_win_lo};
  assign w_adr_hi = {r_ptr_base[31:adr_width], w_win_hi};

`ifdef CHECKER_FEEDER_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !r_stb || wb_ack_i) r_to_cnt <= '0;
    else if (r_to_cnt != 16'hffff)      r_to_cnt <= r_to_cnt + 16'd1;
  end

  assign w_to = r_stb & ~wb_ack_i & (r_to_cnt == 16'hffff);
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_WAIT;
      S_WAIT: begin
        s_ready = 1'b1;
        if (s_valid) w_next = S_WR_LO;
      end
      S_WR_LO: begin
        if (w_ack)     w_next = S_WR_HI;
        else if (w_to) w_next = S_IDLE;
      end
      S_WR_HI: begin
        if (w_ack)     w_next = r_last ? S_DONE : S_WAIT;
        else if (w_to) w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_csr_rd = '0;
    case (csr_a[2:0])
      3'd0:    w_csr_rd = {30'd0, r_irq_en, r_busy};
      3'd1:    w_csr_rd = {r_base, 3'b000};
      3'd2:    w_csr_rd = r_count;
      3'd3:    w_csr_rd = {30'd0, r_timeout, r_done};
      default: w_csr_rd = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_hs) r_data <= s_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_base     <= '0;
      r_ptr_base <= '0;
      r_off      <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_last     <= 1'b0;
      r_stb      <= 1'b0;
      r_cyc      <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_csr_do   <= '0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= csr_di[1];
      if (w_wr_base) r_base   <= csr_di[31:3];
      if (w_wr_stat && csr_di[0]) r_done    <= 1'b0;
      if (w_wr_stat && csr_di[1]) r_timeout <= 1'b0;
      if (w_hs) r_last <= s_last;
      if (w_start) begin
        r_busy     <= 1'b1;
        r_count    <= '0;
        r_off      <= '0;
        r_ptr_base <= {r_base, 3'b000};
        r_done     <= 1'b0;
        r_timeout  <= 1'b0;
      end
      // Strobe rises one cycle after entering a write state and falls on ack, leaving a gap.
      case (r_state)
        S_WR_LO: begin
          if (w_ack) r_stb <= 1'b0;
          else if (!w_to) begin
            r_stb <= 1'b1;
            r_cyc <= 1'b1;
            r_adr <= w_adr_lo;
            r_dat <= r_data[31:0];
          end
        end
        S_WR_HI: begin
          if (w_ack) begin
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_count <= r_count + 32'd1;
            r_off   <= r_off + adr_width'(8);
          end else if (!w_to) begin
            r_stb <= 1'b1;
            r_cyc <= 1'b1;
            r_adr <= w_adr_hi;
            r_dat <= r_data[63:32];
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
      if (w_to) begin
        r_stb     <= 1'b0;
        r_cyc     <= 1'b0;
        r_timeout <= 1'b1;
        r_busy    <= 1'b0;
      end
      r_csr_do <= w_csr_sel ? w_csr_rd : 32'd0;
    end
  end

  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = 4'hf;
  assign wb_stb_o = r_stb;
  assign wb_cyc_o = r_cyc;
  assign wb_we_o  = r_cyc;
  assign csr_do   = r_csr_do;
  assign irq      = r_irq_en & (r_done | r_timeout);

endmodule

// File: tb/tb_checker_wb_feeder.sv
// Scoreboard bench for checker_wb_feeder: expected Wishbone writes are queued per beat and
// compared by the slave model on each ack.
module tb_checker_wb_feeder;
  localparam int AW = 15;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_ready;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o, wb_we_o;
  logic        wb_ack  = 1'b0;
  logic [13:0] csr_a   = '0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = '0;
  logic [31:0] csr_do;
  logic        irq;

  checker_wb_feeder #(.csr_addr(4'h0), .adr_width(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic [31:0] adr; logic [31:0] dat;} wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          ack_delay = 0;
  bit          never_ack = 1'b0;
  bit          prev_ack  = 1'b0;
  int          stall     = 0;
  int          ack_count = 0;
  logic [31:0] ref_adr, ref_dat;
  logic [31:0] cur_base = '0;
  int unsigned cur_off  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input int unsigned off);
    logic [31:0] mask;
    mask = (32'd1 << AW) - 32'd1;
    return (base & ~mask) | ((base + off) & mask);
  endfunction

  // Slave model: acks after ack_delay stall cycles and checks each write against the queue.
  always @(negedge sys_clk) begin
    if (prev_ack) check("stb_gap", wb_stb_o, 1'b0);
    prev_ack = 1'b0;
    if (!wb_stb_o || sys_rst) begin
      wb_ack = 1'b0;
      stall  = 0;
    end else if (never_ack) begin
      wb_ack = 1'b0;
    end else if (stall >= ack_delay) begin
      wb_ack   = 1'b1;
      prev_ack = 1'b1;
      stall    = 0;
      ack_count++;
      if (exp_q.size() == 0) check("sb_underflow", 1'b1, 1'b0);
      else begin
        exp_e = exp_q.pop_front();
        check("wb_adr", wb_adr_o, exp_e.adr);
        check("wb_dat", wb_dat_o, exp_e.dat);
      end
      check("wb_ctl", {wb_cyc_o, wb_we_o, wb_sel_o}, 6'h3f);
    end else begin
      if (stall == 0) begin
        ref_adr = wb_adr_o;
        ref_dat = wb_dat_o;
      end else begin
        check("stall_adr", wb_adr_o, ref_adr);
        check("stall_dat", wb_dat_o, ref_dat);
      end
      check("stall_ready", s_ready, 1'b0);
      stall++;
    end
  end

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a = a; csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] ctrl);
    csr_write(14'd1, base);
    csr_write(14'd0, ctrl);
    cur_base = base;
    cur_off  = 0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, output int n);
    wr_t e;
    e = {exp_adr(cur_base, cur_off), d[31:0]};
    exp_q.push_back(e);
    e = {exp_adr(cur_base, cur_off + 4), d[63:32]};
    exp_q.push_back(e);
    cur_off += 8;
    s_data = d; s_last = last; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    if (!s_ready) check("handshake_wait", 1'b0, 1'b1);
    @(posedge sys_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int i;
    i = 0;
    do begin
      csr_read(14'd0, d);
      i++;
    end while (d[0] && i < 300);
    check("busy_clear", d[0], 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          ac0;
    int          i;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Reset state
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_sel", wb_sel_o, 4'hf);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_csr_do", csr_do, 32'd0);
    for (int k = 0; k < 4; k++) begin
      csr_read(14'(k), d);
      check($sformatf("rst_csr%0d", k), d, 32'd0);
    end

    // Stream is not consumed while idle
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check("idle_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0;

    // BASE low bits read 0, other banks read 0
    csr_write(14'd1, 32'h1234_5677);
    csr_read(14'd1, d);
    check("base_rd", d, 32'h1234_5670);
    csr_read({4'h1, 10'd1}, d);
    check("csr_bank", d, 32'd0);

    // Single run
    start_run(32'h1000, 32'h3);
    send_beat(64'h1111_2222_3333_4444, 1'b0, n);
    send_beat(64'h5555_6666_7777_8888, 1'b1, n);
    check("beat_cycles", n, 5);
    wait_idle();
    check("sb_empty_single", exp_q.size(), 0);
    csr_read(14'd2, d);
    check("count_single", d, 32'd2);
    csr_read(14'd3, d);
    check("stat_single", d, 32'h1);
    csr_read(14'd0, d);
    check("ctrl_single", d, 32'h2);
    check("irq_single", irq, 1'b1);

    // STAT write-1-clear drops irq next cycle
    csr_write(14'd3, 32'h1);
    check("irq_cleared", irq, 1'b0);
    csr_read(14'd3, d);
    check("stat_cleared", d, 32'h0);

    // Address window wrap
    start_run(32'h7ff8, 32'h3);
    send_beat(64'hAAAA_0001_BBBB_0002, 1'b0, n);
    send_beat(64'hCCCC_0003_DDDD_0004, 1'b1, n);
    wait_idle();
    check("sb_empty_wrap", exp_q.size(), 0);
    csr_read(14'd2, d);
    check("count_wrap", d, 32'd2);

    // Slave stall
    ack_delay = 5;
    start_run(32'h0200, 32'h3);
    send_beat(64'h0F0F_1234_F0F0_5678, 1'b1, n);
    wait_idle();
    check("sb_empty_stall", exp_q.size(), 0);
    ack_delay = 0;

    // IRQ_EN cleared: DONE without irq
    start_run(32'h0300, 32'h1);
    send_beat(64'hDEAD_BEEF_CAFE_F00D, 1'b1, n);
    wait_idle();
    csr_read(14'd3, d);
    check("stat_noirq", d, 32'h1);
    check("irq_disabled", irq, 1'b0);
    csr_write(14'd0, 32'h2);
    check("irq_enable_late", irq, 1'b1);
    csr_read(14'd0, d);
    check("ctrl_no_start", d, 32'h2);
    csr_write(14'd3, 32'h1);

    // START while busy is ignored
    start_run(32'h2000, 32'h3);
    send_beat(64'h0101_0202_0303_0404, 1'b0, n);
    csr_write(14'd1, 32'h9000);
    csr_write(14'd0, 32'h3);
    send_beat(64'h0505_0606_0707_0808, 1'b1, n);
    wait_idle();
    check("sb_empty_busy", exp_q.size(), 0);
    csr_read(14'd2, d);
    check("count_busy", d, 32'd2);

    // Reset in the middle of the HI write
    ack_delay = 20;
    start_run(32'h4000, 32'h3);
    ac0 = ack_count;
    send_beat(64'h7777_8888_9999_AAAA, 1'b0, n);
    i = 0;
    while (!(ack_count > ac0 && wb_stb_o) && i < 200) begin
      @(negedge sys_clk);
      i++;
    end
    check("reach_hi", (ack_count > ac0) && wb_stb_o, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("mrst_stb", wb_stb_o, 1'b0);
    check("mrst_cyc", wb_cyc_o, 1'b0);
    check("mrst_irq", irq, 1'b0);
    sys_rst = 1'b0;
    exp_q.delete();
    ack_delay = 0;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check("mrst_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      csr_read(14'(k), d);
      check($sformatf("mrst_csr%0d", k), d, 32'd0);
    end

`ifdef CHECKER_FEEDER_TIMEOUT_EN
    // Slave never acks
    never_ack = 1'b1;
    start_run(32'h0000, 32'h3);
    send_beat(64'h1234_5678_9ABC_DEF0, 1'b1, n);
    i = 0;
    while (!wb_stb_o && i < 20) begin
      @(negedge sys_clk);
      i++;
    end
    i = 0;
    while (wb_stb_o && i < 70000) begin
      @(negedge sys_clk);
      i++;
    end
    check("to_stb", wb_stb_o, 1'b0);
    csr_read(14'd3, d);
    check("to_stat", d, 32'h2);
    check("to_irq", irq, 1'b1);
    csr_read(14'd0, d);
    check("to_ctrl", d, 32'h2);
    exp_q.delete();
    never_ack = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/checker_wb_feeder.md
# checker_wb_feeder

Wishbone master stage directly upstream of the checker core's memory slave port. It takes a 64-bit data stream (host memory words delivered by the DMA/PCIe read path) and writes each beat into the checker's local memory as two consecutive 32-bit Wishbone writes, starting at a CSR-programmed base address. When the stream ends, it signals completion through a status bit and an optional interrupt, so software can then start the checker on the loaded image.

## Interface
Parameters:
- `csr_addr`, 4'h0: CSR bank select, compared against `csr_a[13:10]`.
- `adr_width`, 15: width of the wrapping byte-offset window into checker memory.

Ports:
- `sys_clk` in 1: system clock; all logic on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `s_data` in 64: stream word; low dword written first.
- `s_valid` in 1: stream word valid.
- `s_last` in 1: marks the final word of the image; qualified by `s_valid`.
- `s_ready` out 1: word accepted on the cycle where `s_valid & s_ready`.
- `wb_adr_o` out 32: byte address.
- `wb_dat_o` out 32: write data.
- `wb_sel_o` out 4: always 4'hf.
- `wb_stb_o`, `wb_cyc_o`, `wb_we_o` out 1 each: strobe, cycle and write enable (write-only master).
- `wb_ack_i` in 1: slave acknowledge.
- `csr_a` in 14, `csr_we` in 1, `csr_di` in 32, `csr_do` out 32: CSR bus.
- `irq` out 1: level interrupt.

## Operation
- CSR map (word index `csr_a[2:0]`):
  - 0 CTRL: bit0 START/BUSY, bit1 IRQ_EN.
  - 1 BASE: bits[31:3] byte address; bits[2:0] always read 0.
  - 2 COUNT: read-only, 64-bit beats written in the current or last run.
  - 3 STAT: bit0 DONE, bit1 TIMEOUT (see Configuration); write 1 to clear.
- START (CTRL bit0 written 1 while IDLE) does the following:
  - copies BASE to the address pointer;
  - clears COUNT and STAT;
  - enters WAIT.
- Writing START while busy is ignored. IRQ_EN stays writable at any time.
- FSM:
  - IDLE: `s_ready`=0.
  - WAIT: `s_ready`=1. On a handshake, latch data and last, go to WR_LO.
  - WR_LO: `stb/cyc/we`=1, `adr`=ptr, `dat`=data[31:0]. On ack go to WR_HI.
  - WR_HI: `adr`=ptr+4, `dat`=data[63:32]. On ack, COUNT+1, ptr+8, then go to DONE if last was set, otherwise WAIT.
  - DONE: set STAT.DONE, clear BUSY, go to IDLE.
- Address pointer: `wb_adr_o` = {BASE[31:adr_width], (BASE[adr_width-1:0] + offset) mod 2^adr_width}. The offset wraps silently within the window.
- COUNT is 32 bits and wraps silently.
- `irq` = STAT.DONE & CTRL.IRQ_EN (ORed with STAT.TIMEOUT & IRQ_EN when timeout is compiled in).
- A stream word with `s_valid` while IDLE is not consumed: `s_ready` stays 0.

## Timing
- Reset values:
  - all outputs 0, except `wb_sel_o` = 4'hf;
  - all CSRs 0;
  - FSM in IDLE.
- Reset mid-transfer: `stb/cyc` drop on the reset edge. The pending beat is lost and no ack is awaited.
- `csr_do` is registered: 1-cycle read latency. It reads 0 when `csr_a[13:10]` != `csr_addr`.
- A CSR write takes effect the cycle after `csr_we`.
- A CSR write-1-clear of STAT.DONE on the same cycle DONE is being set: the set wins.
- Wishbone outputs are registered. `stb` asserts on the cycle after the state is entered and is held until `wb_ack_i`.
- After an ack, `stb` deasserts for at least one cycle between LO and HI.
- With a 1-cycle-ack slave, the minimum cost is 5 cycles per beat, from handshake to the next `s_ready`.
- `s_last` on the first beat gives a single-beat run; DONE is set 1 cycle after the HI ack.

## Configuration
- `CHECKER_FEEDER_TIMEOUT_EN` defined: a 16-bit counter runs while `stb` is high.
  - At 0xffff with no ack: drop `stb/cyc`, set STAT.TIMEOUT, clear BUSY, go to IDLE. DONE is not set.
  - The counter clears on every ack.
- Not defined: no counter, and STAT bit1 reads 0. The master waits for ack indefinitely.

## Test plan
- **Single run:** BASE=0x1000, START|IRQ_EN, send beats 0x1111_2222_3333_4444 and 0x5555_6666_7777_8888 (last).
  - Required writes, in order: 0x1000←0x33334444, 0x1004←0x11112222, 0x1008←0x77778888, 0x100c←0x55556666.
  - Required end state: COUNT=2, DONE=1, `irq`=1.
- **Wrap:** adr_width=15, BASE=0x7ff8, two beats → writes at 0x7ff8, 0x7ffc, 0x0000, 0x0004.
- **Slave stall:** ack delayed 5 cycles → `stb` and `dat` held stable throughout; `s_ready` stays 0 until the HI ack.
- **Mid-run reset:** assert `sys_rst` while in WR_HI with `stb` high → `stb/cyc/irq`=0 next edge, CSRs 0, an incoming `s_valid` is not accepted.
- **Control corner cases:**
  - START while BUSY → COUNT not cleared, run continues.
  - STAT write 0x1 after done → `irq` drops 1 cycle later.
  - IRQ_EN=0 → `irq` stays 0 with DONE=1.
- **Timeout (macro defined):** slave never acks → after 65535 cycles `stb`=0, STAT=0x2, `irq`=1 with IRQ_EN.
